adder_arbiter: RTL and testbench
================================

// Module: adder_arbiter
// PURPOSE
//  Shares one 32-bit add/subtract unit between N_REQ requesters (PC increment, branch target,
//  address calc, ALU) in the unpipelined core. Round-robin arbitration, latched operands,
//  one registered compute cycle, result held with a valid/ack handshake until consumed.
// PARAMETERS
//  N_REQ   4   number of requesters, >=2; index width IDW = $clog2(N_REQ)
//  WIDTH   32  operand/result width
// PORTS
//  i_clk     in   1            rising-edge clock
//  i_rst     in   1            synchronous active-high reset
//  i_req     in   N_REQ        request per requester; level, held until o_gnt bit seen
//  i_sub     in   N_REQ        per requester: 1 = op1 - op2, 0 = op1 + op2
//  i_op1     in   N_REQ*WIDTH  flattened operand 1; requester k at [k*WIDTH +: WIDTH]
//  i_op2     in   N_REQ*WIDTH  flattened operand 2, same packing
//  i_ack     in   1            consumer accepts o_result while o_valid=1
//  o_gnt     out  N_REQ        one-hot grant, high exactly one cycle (operands captured)
//  o_busy    out  1            1 whenever state != IDLE
//  o_valid   out  1            o_result/o_id/flags valid
//  o_id      out  IDW          index of requester owning o_result
//  o_result  out  WIDTH        sum/difference mod 2^WIDTH
//  o_carry   out  1            carry out of MSB (add); NOT borrow, i.e. 1 = no borrow (sub)
//  o_ovf     out  1            signed two's-complement overflow
// BEHAVIOUR
//  Reset (i_rst=1 at edge): state=IDLE, ptr=0, all outputs 0; wins over every other input,
//   including mid-CALC/RESP: pending result discarded, no o_valid produced.
//  FSM states IDLE -> CALC -> RESP -> IDLE; all outputs registered.
//  IDLE: if i_req != 0: winner = first set bit scanning ptr, ptr+1, ... wrapping mod N_REQ;
//   latch op1/op2/sub of winner, o_gnt <= onehot(winner), o_id <= winner, ptr <= (winner+1)
//   mod N_REQ, state <= CALC. If i_req == 0: stay, ptr unchanged.
//  CALC: o_gnt <= 0; o_result <= op1 + (sub ? ~op2 : op2) + sub in WIDTH+1 bits,
//   o_carry <= bit WIDTH; o_ovf <= (a[MSB]==b'[MSB]) && (r[MSB]!=a[MSB]) with b' = effective
//   op2; o_valid <= 1; state <= RESP. Requester inputs ignored (operands already latched).
//  RESP: outputs held stable; on i_ack=1: o_valid <= 0, state <= IDLE. New requests wait.
//   o_result/o_id/flags keep last value after o_valid drops (not cleared).
//  Latency: i_req sampled in IDLE at edge T -> o_gnt high T..T+1, o_valid high from edge T+1;
//   earliest next grant at edge after i_ack, i.e. throughput 1 op / 3 cycles.
//  i_ack outside RESP ignored. A requester dropping i_req before grant simply loses its turn.
//  Fairness: with all requesters continuously asserting, grants cycle 0,1,2,3,0,...
//  Single requester continuously asserting is granted every op (ptr skips idle lines).
// TESTING
//  1 Reset: hold i_rst 2 cycles mid-RESP -> o_valid=0, o_gnt=0, o_busy=0, next grant to req 0.
//  2 Add: req1 op1=0x0000_0005 op2=0x0000_0007 sub=0 -> o_gnt=4'b0010 one cycle, then
//    o_valid=1 o_id=1 o_result=0x0000_000C carry=0 ovf=0; held until i_ack.
//  3 Wrap/overflow: op1=0xFFFF_FFFF+0x1 -> result 0, carry=1, ovf=0; 0x7FFF_FFFF+0x1 ->
//    0x8000_0000, carry=0, ovf=1.
//  4 Sub: 3-5 -> 0xFFFF_FFFE, carry=0 (borrow), ovf=0; 0x8000_0000-1 -> 0x7FFF_FFFF, ovf=1.
//  5 Round-robin: i_req=4'b1111 held, ack immediately -> o_id sequence 0,1,2,3,0; then
//    i_req=4'b0101 -> 2,0,2,0.
//  6 Backpressure: withhold i_ack 10 cycles -> o_result stable, no o_gnt; operand changes on
//    granted requester after grant do not alter o_result.

Source files
------------

// File: rtl/adder_arbiter.sv
// One shared WIDTH-bit add/subtract unit behind a round-robin arbiter.
// The winner's operands are latched, computed in one cycle and held under valid/ack.
module adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ-1:0]       i_sub,
  input  logic [N_REQ*WIDTH-1:0] i_op1,
  input  logic [N_REQ*WIDTH-1:0] i_op2,
  input  logic                   i_ack,
  output logic [N_REQ-1:0]       o_gnt,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [IDW-1:0]         o_id,
  output logic [WIDTH-1:0]       o_result,
  output logic                   o_carry,
  output logic                   o_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic               sub_q, sub_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   op1_arr [N_REQ];
  logic [WIDTH-1:0]   op2_arr [N_REQ];
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     cand;
  logic               found;
  int                 scan_idx;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign op1_arr[gi] = i_op1[gi*WIDTH +: WIDTH];
    assign op2_arr[gi] = i_op2[gi*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    sub_d    = sub_q;
    gnt_d    = gnt_q;
    valid_d  = valid_q;
    id_d     = id_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    winner   = '0;
    cand     = '0;
    found    = 1'b0;
    scan_idx = 0;

    // Scan starting at ptr and wrapping; first asserted line wins.
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % N_REQ;
      cand     = IDW'(scan_idx);
      if (!found && i_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    b_eff = sub_q ? ~op2_q : op2_q;
    sum   = {1'b0, op1_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_q};

    case (state_q)
      IDLE: begin
        if (found) begin
          op1_d         = op1_arr[winner];
          op2_d         = op2_arr[winner];
          sub_d         = i_sub[winner];
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          id_d          = winner;
          ptr_d         = (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);
          state_d       = CALC;
        end
      end
      CALC: begin
        gnt_d    = '0;
        result_d = sum[WIDTH-1:0];
        carry_d  = sum[WIDTH];
        ovf_d    = (op1_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op1_q[WIDTH-1]);
        valid_d  = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (i_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      sub_q    <= 1'b0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sub_q    <= sub_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_gnt    = gnt_q;
  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_id     = id_q;
  assign o_result = result_q;
  assign o_carry  = carry_q;
  assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, add/sub flags, round-robin order, backpressure.
module tb_adder_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   sub;
  logic [127:0] op1;
  logic [127:0] op2;
  logic         ack;
  logic [3:0]   gnt;
  logic         busy;
  logic         valid;
  logic [1:0]   id;
  logic [31:0]  result;
  logic         carry;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  adder_arbiter #(.N_REQ(4), .WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_sub(sub), .i_op1(op1), .i_op2(op2),
    .i_ack(ack), .o_gnt(gnt), .o_busy(busy), .o_valid(valid), .o_id(id),
    .o_result(result), .o_carry(carry), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic s);
    op1[k*32 +: 32] = a;
    op2[k*32 +: 32] = b;
    sub[k] = s;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8 && !ok; n++) begin
      tick();
      if (gnt != 4'b0000) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8 && !ok; n++) begin
      tick();
      if (valid) ok = 1'b1;
    end
  endtask

  // Single operation on requester k; returns what was observed while o_valid=1, then acks.
  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] r, output logic c, output logic v,
                       output logic [1:0] idv, output bit ok);
    bit ok2;
    set_op(k, a, b, s);
    req[k] = 1'b1;
    wait_gnt(ok);
    req[k] = 1'b0;
    wait_valid(ok2);
    ok = ok && ok2;
    r = result;
    c = carry;
    v = ovf;
    idv = id;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({gnt, busy, valid, id, result, carry, ovf} !== 41'd0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b busy=%b valid=%b id=%0d result=%h c=%b v=%b, want all 0",
               gnt, busy, valid, id, result, carry, ovf);
    end
  endtask

  task automatic test_add();
    bit ok;
    set_op(1, 32'h0000_0005, 32'h0000_0007, 1'b0);
    req = 4'b0010;
    wait_gnt(ok);
    checks++;
    if (!ok || gnt !== 4'b0010 || busy !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL add_grant: got ok=%0d gnt=%b busy=%b valid=%b, want gnt=0010 busy=1 valid=0",
               ok, gnt, busy, valid);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || valid !== 1'b1 || id !== 2'd1 || result !== 32'h0000_000C ||
        carry !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL add_result: got gnt=%b valid=%b id=%0d result=%h c=%b v=%b, want 0000 1 1 0000000c 0 0",
               gnt, valid, id, result, carry, ovf);
    end
    tick();
    tick();
    checks++;
    if (valid !== 1'b1 || result !== 32'h0000_000C) begin
      failures++;
      $display("FAIL add_hold: got valid=%b result=%h, want 1 0000000c", valid, result);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0000_000C) begin
      failures++;
      $display("FAIL add_ack: got valid=%b busy=%b result=%h, want 0 0 0000000c", valid, busy, result);
    end
    $display("add: id=%0d result=%h", id, result);
  endtask

  task automatic test_wrap();
    logic [31:0] r; logic c, v; logic [1:0] i; bit ok;
    do_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, r, c, v, i, ok);
    checks++;
    if (!ok || r !== 32'h0 || c !== 1'b1 || v !== 1'b0 || i !== 2'd2) begin
      failures++;
      $display("FAIL wrap_carry: got ok=%0d r=%h c=%b v=%b id=%0d, want 00000000 1 0 2", ok, r, c, v, i);
    end
    $display("wrap: ffffffff+1 -> %h c=%b v=%b", r, c, v);
    do_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, r, c, v, i, ok);
    checks++;
    if (!ok || r !== 32'h8000_0000 || c !== 1'b0 || v !== 1'b1) begin
      failures++;
      $display("FAIL add_ovf: got ok=%0d r=%h c=%b v=%b, want 80000000 0 1", ok, r, c, v);
    end
    $display("wrap: 7fffffff+1 -> %h c=%b v=%b", r, c, v);
  endtask

  task automatic test_sub();
    logic [31:0] r; logic c, v; logic [1:0] i; bit ok;
    do_op(3, 32'h0000_0003, 32'h0000_0005, 1'b1, r, c, v, i, ok);
    checks++;
    if (!ok || r !== 32'hFFFF_FFFE || c !== 1'b0 || v !== 1'b0 || i !== 2'd3) begin
      failures++;
      $display("FAIL sub_borrow: got ok=%0d r=%h c=%b v=%b id=%0d, want fffffffe 0 0 3", ok, r, c, v, i);
    end
    $display("sub: 3-5 -> %h c=%b v=%b", r, c, v);
    do_op(3, 32'h8000_0000, 32'h0000_0001, 1'b1, r, c, v, i, ok);
    checks++;
    if (!ok || r !== 32'h7FFF_FFFF || c !== 1'b1 || v !== 1'b1) begin
      failures++;
      $display("FAIL sub_ovf: got ok=%0d r=%h c=%b v=%b, want 7fffffff 1 1", ok, r, c, v);
    end
    $display("sub: 80000000-1 -> %h c=%b v=%b", r, c, v);
  endtask

  task automatic rr_step(output logic [1:0] gid, output bit ok);
    bit ok2;
    wait_gnt(ok);
    gid = id;
    wait_valid(ok2);
    ok = ok && ok2;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] gid; bit ok;
    int exp_all [5] = '{0, 1, 2, 3, 0};
    int exp_odd [4] = '{2, 0, 2, 0};
    apply_reset();
    for (int k = 0; k < 4; k++) set_op(k, 32'(k * 16), 32'd1, 1'b0);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      rr_step(gid, ok);
      checks++;
      if (!ok || gid !== 2'(exp_all[n])) begin
        failures++;
        $display("FAIL rr_all[%0d]: got ok=%0d id=%0d, want %0d", n, ok, gid, exp_all[n]);
      end
      $display("rr 1111: grant %0d id=%0d", n, gid);
    end
    req = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      rr_step(gid, ok);
      checks++;
      if (!ok || gid !== 2'(exp_odd[n])) begin
        failures++;
        $display("FAIL rr_0101[%0d]: got ok=%0d id=%0d, want %0d", n, ok, gid, exp_odd[n]);
      end
      $display("rr 0101: grant %0d id=%0d", n, gid);
    end
    req = 4'b1000;
    for (int n = 0; n < 2; n++) begin
      rr_step(gid, ok);
      checks++;
      if (!ok || gid !== 2'd3) begin
        failures++;
        $display("FAIL rr_single[%0d]: got ok=%0d id=%0d, want 3", n, ok, gid);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    int bad = 0;
    apply_reset();
    set_op(0, 32'h0000_0100, 32'h0000_0023, 1'b0);
    set_op(2, 32'h0000_0010, 32'h0000_0001, 1'b1);
    req = 4'b0001;
    wait_gnt(ok);
    set_op(0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    req = 4'b0101;
    wait_valid(ok2);
    checks++;
    if (!ok || !ok2 || result !== 32'h0000_0123 || id !== 2'd0) begin
      failures++;
      $display("FAIL bp_result: got ok=%0d/%0d result=%h id=%0d, want 00000123 0", ok, ok2, result, id);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (result !== 32'h0000_0123 || gnt !== 4'b0000 || valid !== 1'b1) begin
        failures++;
        bad++;
        $display("FAIL bp_hold[%0d]: got result=%h gnt=%b valid=%b, want 00000123 0000 1",
                 n, result, gnt, valid);
      end
    end
    $display("backpressure: held 10 cycles, bad=%0d", bad);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    wait_gnt(ok);
    checks++;
    if (!ok || gnt !== 4'b0100 || id !== 2'd2) begin
      failures++;
      $display("FAIL bp_next: got ok=%0d gnt=%b id=%0d, want 0100 2", ok, gnt, id);
    end
    req = 4'b0000;
    wait_valid(ok);
    checks++;
    if (!ok || result !== 32'h0000_000F) begin
      failures++;
      $display("FAIL bp_next_result: got ok=%0d result=%h, want 0000000f", ok, result);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_resp();
    bit ok, ok2;
    set_op(1, 32'h0000_0AAA, 32'h0000_0555, 1'b0);
    req = 4'b0010;
    wait_gnt(ok);
    req = 4'b0000;
    wait_valid(ok2);
    checks++;
    if (!ok || !ok2 || result !== 32'h0000_0FFF) begin
      failures++;
      $display("FAIL midreset_pre: got ok=%0d/%0d result=%h, want 00000fff", ok, ok2, result);
    end
    apply_reset();
    checks++;
    if (valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got valid=%b gnt=%b busy=%b result=%h, want 0 0000 0 00000000",
               valid, gnt, busy, result);
    end
    for (int k = 0; k < 4; k++) set_op(k, 32'd7, 32'd7, 1'b0);
    req = 4'b1111;
    wait_gnt(ok);
    checks++;
    if (!ok || gnt !== 4'b0001 || id !== 2'd0) begin
      failures++;
      $display("FAIL midreset_next: got ok=%0d gnt=%b id=%0d, want 0001 0", ok, gnt, id);
    end
    $display("reset mid-RESP: next grant gnt=%b", gnt);
    req = 4'b0000;
    wait_valid(ok);
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    sub = '0;
    op1 = '0;
    op2 = '0;
    ack = 1'b0;
    test_reset();
    test_add();
    test_wrap();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_reset_mid_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
